instr_sequencer: RTL and testbench
==================================

# instr_sequencer

Multi-cycle control unit for the simple processor: sequences fetch, decode, execute and write-back for one 12-bit instruction per accepted step request. It drives the program-counter enable, register-file, ALU and data-memory control lines. A step comes from the debounced left button, an optional free-running run timer, or a switch-supplied external instruction. It replaces the direct button-to-PC connection; the PC increments only via `pc_inc`.

## Interface
- `RUN_PERIOD`, default 100_000_000: clk cycles between auto-steps in run mode; minimum 8.
- `clk` in 1: system clock.
- `rst` in 1: reset, asynchronous, active-high.
- `step` in 1: one-cycle debounced step pulse.
- `run` in 1: level; when high, internal timer generates steps.
- `ext_sel` in 1: level; when high, an accepted step executes `ext_instr` instead of `im_data`.
- `ext_instr` in 12: switch-entered instruction.
- `im_data` in 12: instruction memory read data; synchronous ROM, 1-cycle latency, addressed by PC.
- `pc_inc` out 1: one-cycle PC increment enable.
- `rf_ra1`, `rf_ra2` out 3: register-file read addresses.
- `rf_wa` out 3: register-file write address.
- `rf_we` out 1: register-file write enable.
- `wb_sel` out 1: write-back source; 0 = data memory, 1 = ALU.
- `alu_op` out 1: 0 = add, 1 = subtract.
- `dm_addr` out 4: data-memory address.
- `dm_we` out 1: data-memory write enable.
- `busy` out 1: high in every state except IDLE and HALTED.
- `halted` out 1: high in HALTED.

## Operation
- Instruction format: opcode `[11:9]`; operand fields depend on the opcode.
  - 000 LOAD: R[`[2:0]`] <- DM[`[7:4]`].
  - 001 STORE: DM[`[7:4]`] <- R[`[2:0]`].
  - 010 ADD: R[`[8:6]`] <- R[`[5:3]`] + R[`[2:0]`].
  - 011 SUB: R[`[8:6]`] <- R[`[5:3]`] - R[`[2:0]`].
  - 111 HALT.
  - 100–110: NOP.
- Step accept:
  - `step` or run-timer tick is accepted only in IDLE.
  - Requests arriving in any other state are dropped, not queued.
  - `ext_sel` is sampled at accept and held for the rest of the instruction.
- FSM transitions:
  - IDLE -> FETCH on accept.
  - FETCH -> DECODE.
  - DECODE: latches the IR from `im_data`, or from `ext_instr` if external; -> EXEC.
  - EXEC: drives read addresses and `dm_addr`; STORE asserts `dm_we`; -> WB.
  - WB: LOAD/ADD/SUB assert `rf_we`; `pc_inc` pulses unless external; -> IDLE.
  - HALT decoded in EXEC -> HALTED. `pc_inc` never fires for HALT.
- HALTED exits only via `rst`.
- Run timer:
  - Counts 0..RUN_PERIOD-1 while `run` is high and the FSM is not HALTED.
  - Issues a tick at wrap.
  - Clears to 0 when `run` is low.
- Control outputs are registered and decoded from the IR and state only; no dependence on live `im_data` after DECODE.
- Arithmetic width: the ALU (external) is 4-bit and wraps; no flags are produced here.

## Timing
- Reset values: state IDLE, IR = 0, run counter = 0. All outputs are 0, including `busy` and `halted`.
- Latency: accept at edge 0; FETCH cycle 1, DECODE 2, EXEC 3, WB 4; back in IDLE at cycle 5. The next step is accepted at cycle 5 at the earliest.
- `dm_we` is high exactly one cycle (EXEC). `rf_we` and `pc_inc` are high exactly one cycle (WB).
- For LOAD, `dm_addr` is held EXEC through WB; synchronous DM data is valid in WB.
- `rst` mid-instruction: returns to IDLE immediately. No pending `rf_we`/`dm_we`/`pc_inc` is issued.
- `step` and a run tick in the same IDLE cycle: one instruction only.
- PC wrap (7->0) is the PC's responsibility; the sequencer keeps pulsing `pc_inc`.

## Structure
- Package `proc_pkg`:
  - `opcode_t` enum (LOAD, STORE, ADD, SUB, HALT).
  - `seq_state_t` enum (IDLE, FETCH, DECODE, EXEC, WB, HALTED).
  - Field-position constants.
  - Instruction width 12, register-address width 3, data-memory-address width 4.
- One sub-module: `step_timer`, which implements the RUN_PERIOD counter and tick generation.

## Test plan
- Reset, then `step` with `im_data`=12'h015 (LOAD R5<-DM[1]) -> `dm_addr`=1 in EXEC and WB; `wb_sel`=0, `rf_wa`=5, `rf_we` in WB; `pc_inc` 1 cycle at cycle 4.
- ADD 12'h48A (R2<-R1+R2) -> `rf_ra1`=1, `rf_ra2`=2, `rf_wa`=2, `alu_op`=0, `wb_sel`=1. SUB 12'h6CB -> `alu_op`=1, `rf_wa`=3.
- `ext_sel`=1, `ext_instr`=12'h237 (STORE DM[3]<-R7) -> `dm_we` 1 cycle with `dm_addr`=3, `rf_ra2`=7; `pc_inc` stays 0.
- `step` pulses at cycles 0, 2, 4 -> exactly one instruction, one `pc_inc`. HALT 12'hE00 -> `halted`=1, later steps ignored until `rst`.
- `run`=1 with RUN_PERIOD=8 -> one instruction every 8 cycles. `rst` asserted in EXEC of a STORE -> no `dm_we`, outputs 0, state IDLE.

Source files
------------

// File: rtl/proc_pkg.sv
// -----------------------------------------------------------------------------
// proc_pkg
// Shared types and constants for the simple processor control path:
//   - instruction geometry (12-bit word, 3-bit register fields, 4-bit DM address)
//   - opcode and sequencer-state enumerations
//   - ctl_t, the bundle of registered control lines driven by instr_sequencer
// No ports; imported with `import proc_pkg::*;`.
// -----------------------------------------------------------------------------
package proc_pkg;

    localparam int INSTR_W  = 12;
    localparam int RADDR_W  = 3;
    localparam int DMADDR_W = 4;
    localparam int OPC_W    = 3;

    // Field positions (LSB of each field) inside the instruction word
    localparam int OPC_LSB  = 9;   // opcode      [11:9]
    localparam int RD_LSB   = 6;   // ALU dest    [8:6]
    localparam int RS1_LSB  = 3;   // ALU src 1   [5:3]
    localparam int RS2_LSB  = 0;   // ALU src 2 / LOAD dest / STORE src [2:0]
    localparam int DMA_LSB  = 4;   // DM address  [7:4]

    // Opcodes 100..110 are NOPs and deliberately have no enumerator.
    typedef enum logic [OPC_W-1:0] {
        OP_LOAD  = 3'b000,
        OP_STORE = 3'b001,
        OP_ADD   = 3'b010,
        OP_SUB   = 3'b011,
        OP_HALT  = 3'b111
    } opcode_t;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_WB     = 3'd4,
        S_HALTED = 3'd5
    } seq_state_t;

    typedef struct packed {
        logic                pc_inc;
        logic [RADDR_W-1:0]  rf_ra1;
        logic [RADDR_W-1:0]  rf_ra2;
        logic [RADDR_W-1:0]  rf_wa;
        logic                rf_we;
        logic                wb_sel;
        logic                alu_op;
        logic [DMADDR_W-1:0] dm_addr;
        logic                dm_we;
        logic                busy;
        logic                halted;
    } ctl_t;

    function automatic logic [OPC_W-1:0] opc_of(input logic [INSTR_W-1:0] ir);
        return ir[OPC_LSB +: OPC_W];
    endfunction

    function automatic logic [RADDR_W-1:0] reg_at(input logic [INSTR_W-1:0] ir,
                                                  input int lsb);
        return ir[lsb +: RADDR_W];
    endfunction

    function automatic logic [DMADDR_W-1:0] dma_of(input logic [INSTR_W-1:0] ir);
        return ir[DMA_LSB +: DMADDR_W];
    endfunction

endpackage

// File: rtl/step_timer.sv
// -----------------------------------------------------------------------------
// step_timer
// Free-running run-mode step generator. Counts 0..RUN_PERIOD-1 while `run`
// is high and `hold` is low, and emits a one-cycle `tick` on the wrap cycle.
// The count is cleared whenever `run` is low, so the first tick after raising
// `run` arrives RUN_PERIOD cycles later.
// Ports:
//   clk, rst  - clock, asynchronous active-high reset
//   run       - level enable for the timer
//   hold      - freezes the count (used while the sequencer is HALTED)
//   tick      - one-cycle step request at wrap
// -----------------------------------------------------------------------------
module step_timer #(
    parameter int unsigned RUN_PERIOD = 100_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic hold,
    output logic tick
);

    localparam int CNT_W = $clog2(RUN_PERIOD);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(RUN_PERIOD - 1);

    logic [CNT_W-1:0] cnt;
    logic             counting;

    assign counting = run && !hold;
    assign tick     = counting && (cnt == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (!run) begin
            cnt <= '0;
        end else if (counting) begin
            cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/instr_sequencer.sv
// -----------------------------------------------------------------------------
// instr_sequencer
// Multi-cycle control unit: runs FETCH, DECODE, EXEC, WB for one 12-bit
// instruction per accepted step and drives the PC, register-file, ALU and
// data-memory control lines. Steps come from `step` or the run timer and are
// only accepted in IDLE; the instruction comes from the ROM or, if `ext_sel`
// was high at accept, from the switches.
// Ports:
//   clk, rst            - clock, asynchronous active-high reset
//   step                - one-cycle debounced step request
//   run                 - enables the internal step timer
//   ext_sel, ext_instr  - external (switch) instruction select and value
//   im_data             - instruction ROM read data (valid in DECODE)
//   pc_inc              - one-cycle PC increment (WB, non-external, non-HALT)
//   rf_ra1, rf_ra2      - register-file read addresses
//   rf_wa, rf_we        - register-file write address / enable
//   wb_sel              - write-back source (0 = DM, 1 = ALU)
//   alu_op              - 0 = add, 1 = subtract
//   dm_addr, dm_we      - data-memory address / write enable
//   busy, halted        - status
// -----------------------------------------------------------------------------
module instr_sequencer
    import proc_pkg::*;
#(
    parameter int unsigned RUN_PERIOD = 100_000_000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                step,
    input  logic                run,
    input  logic                ext_sel,
    input  logic [INSTR_W-1:0]  ext_instr,
    input  logic [INSTR_W-1:0]  im_data,
    output logic                pc_inc,
    output logic [RADDR_W-1:0]  rf_ra1,
    output logic [RADDR_W-1:0]  rf_ra2,
    output logic [RADDR_W-1:0]  rf_wa,
    output logic                rf_we,
    output logic                wb_sel,
    output logic                alu_op,
    output logic [DMADDR_W-1:0] dm_addr,
    output logic                dm_we,
    output logic                busy,
    output logic                halted
);

    seq_state_t         state_q, state_d;
    logic [INSTR_W-1:0] ir_q, ir_d;
    logic               ext_q, ext_d;
    ctl_t               ctl_q, ctl_d;
    logic               tick;
    logic               is_halted;
    logic [OPC_W-1:0]   opc_q, opc_d;

    assign is_halted = (state_q == S_HALTED);

    step_timer #(
        .RUN_PERIOD (RUN_PERIOD)
    ) u_step_timer (
        .clk  (clk),
        .rst  (rst),
        .run  (run),
        .hold (is_halted),
        .tick (tick)
    );

    // State, IR, external flag and registered control lines
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            ir_q    <= '0;
            ext_q   <= 1'b0;
            ctl_q   <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            ext_q   <= ext_d;
            ctl_q   <= ctl_d;
        end
    end

    assign opc_q = opc_of(ir_q);

    // Next state. A step and a timer tick in the same IDLE cycle collapse
    // into one accept; requests outside IDLE are simply not looked at.
    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        ext_d   = ext_q;
        case (state_q)
            S_IDLE: begin
                if (step || tick) begin
                    state_d = S_FETCH;
                    ext_d   = ext_sel;
                end
            end
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                ir_d    = ext_q ? ext_instr : im_data;
                state_d = S_EXEC;
            end
            S_EXEC:   state_d = (opc_q == OP_HALT) ? S_HALTED : S_WB;
            S_WB:     state_d = S_IDLE;
            S_HALTED: state_d = S_HALTED;
            default:  state_d = S_IDLE;
        endcase
    end

    // Control lines are registered: decode the state and IR that will be
    // current next cycle, so EXEC/WB outputs appear exactly in those states
    // and never depend on live im_data once it has been latched.
    assign opc_d = opc_of(ir_d);

    always_comb begin
        ctl_d        = '0;
        ctl_d.busy   = (state_d == S_FETCH) || (state_d == S_DECODE) ||
                       (state_d == S_EXEC)  || (state_d == S_WB);
        ctl_d.halted = (state_d == S_HALTED);

        if ((state_d == S_EXEC) || (state_d == S_WB)) begin
            case (opc_d)
                OP_LOAD: begin
                    // DM address held through WB so synchronous read data lands there
                    ctl_d.dm_addr = dma_of(ir_d);
                    ctl_d.rf_wa   = reg_at(ir_d, RS2_LSB);
                    ctl_d.wb_sel  = 1'b0;
                    ctl_d.rf_we   = (state_d == S_WB);
                end
                OP_STORE: begin
                    ctl_d.dm_addr = dma_of(ir_d);
                    ctl_d.rf_ra2  = reg_at(ir_d, RS2_LSB);
                    ctl_d.dm_we   = (state_d == S_EXEC);
                end
                OP_ADD, OP_SUB: begin
                    ctl_d.rf_ra1  = reg_at(ir_d, RS1_LSB);
                    ctl_d.rf_ra2  = reg_at(ir_d, RS2_LSB);
                    ctl_d.rf_wa   = reg_at(ir_d, RD_LSB);
                    ctl_d.wb_sel  = 1'b1;
                    ctl_d.alu_op  = (opc_d == OP_SUB);
                    ctl_d.rf_we   = (state_d == S_WB);
                end
                default: ;
            endcase

            // HALT never reaches WB, so it never increments the PC
            ctl_d.pc_inc = (state_d == S_WB) && !ext_d;
        end
    end

    assign pc_inc  = ctl_q.pc_inc;
    assign rf_ra1  = ctl_q.rf_ra1;
    assign rf_ra2  = ctl_q.rf_ra2;
    assign rf_wa   = ctl_q.rf_wa;
    assign rf_we   = ctl_q.rf_we;
    assign wb_sel  = ctl_q.wb_sel;
    assign alu_op  = ctl_q.alu_op;
    assign dm_addr = ctl_q.dm_addr;
    assign dm_we   = ctl_q.dm_we;
    assign busy    = ctl_q.busy;
    assign halted  = ctl_q.halted;

endmodule

// File: tb/tb_instr_sequencer.sv
// -----------------------------------------------------------------------------
// tb_instr_sequencer
// Directed bench for instr_sequencer with RUN_PERIOD = 8. Output snapshots are
// packed as {pc_inc, ra1, ra2, wa, rf_we, wb_sel, alu_op, dm_addr, dm_we,
// busy, halted} and compared with hand-computed vectors.
// -----------------------------------------------------------------------------
module tb_instr_sequencer;

    logic        clk = 1'b0;
    logic        rst, step, run, ext_sel;
    logic [11:0] ext_instr, im_data;
    logic        pc_inc, rf_we, wb_sel, alu_op, dm_we, busy, halted;
    logic [2:0]  rf_ra1, rf_ra2, rf_wa;
    logic [3:0]  dm_addr;

    int n_checks = 0;
    int n_fail   = 0;

    instr_sequencer #(.RUN_PERIOD(8)) dut (
        .clk(clk), .rst(rst), .step(step), .run(run),
        .ext_sel(ext_sel), .ext_instr(ext_instr), .im_data(im_data),
        .pc_inc(pc_inc), .rf_ra1(rf_ra1), .rf_ra2(rf_ra2), .rf_wa(rf_wa),
        .rf_we(rf_we), .wb_sel(wb_sel), .alu_op(alu_op), .dm_addr(dm_addr),
        .dm_we(dm_we), .busy(busy), .halted(halted)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [19:0] snap();
        return {pc_inc, rf_ra1, rf_ra2, rf_wa, rf_we, wb_sel, alu_op,
                dm_addr, dm_we, busy, halted};
    endfunction

    function automatic logic [19:0] mk(input logic pc, input logic [2:0] ra1,
                                       input logic [2:0] ra2, input logic [2:0] wa,
                                       input logic we, input logic wbs, input logic alu,
                                       input logic [3:0] dma, input logic dmwe,
                                       input logic bsy, input logic hlt);
        return {pc, ra1, ra2, wa, we, wbs, alu, dma, dmwe, bsy, hlt};
    endfunction

    // Advance to just after the next active edge
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Issue one step and check cycles 1..5 (FETCH, DECODE, EXEC, WB, IDLE).
    // ext_sel is dropped right after accept to show it is held internally.
    task automatic run_instr(input string name, input logic [11:0] rom,
                             input logic ext, input logic [11:0] sw,
                             input logic [19:0] e_exec, input logic [19:0] e_wb);
        logic [19:0] only_busy;
        only_busy = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        im_data   = rom;
        ext_sel   = ext;
        ext_instr = sw;
        step      = 1'b1;
        cyc();
        step      = 1'b0;
        ext_sel   = 1'b0;
        chk({name, "_fetch"}, 32'(snap()), 32'(only_busy));
        cyc();
        chk({name, "_decode"}, 32'(snap()), 32'(only_busy));
        cyc();
        chk({name, "_exec"}, 32'(snap()), 32'(e_exec));
        cyc();
        chk({name, "_wb"}, 32'(snap()), 32'(e_wb));
        cyc();
        chk({name, "_idle"}, 32'(snap()), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int pcs, bsy, hlt, bad;
        logic exp_pc;

        rst = 1'b1; step = 1'b0; run = 1'b0; ext_sel = 1'b0;
        ext_instr = '0; im_data = '0;
        #12;
        chk("reset_outputs", 32'(snap()), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        cyc();

        // LOAD R5 <- DM[1]
        run_instr("load", 12'h015, 1'b0, 12'h000,
                  mk(0, 0, 0, 5, 0, 0, 0, 1, 0, 1, 0),
                  mk(1, 0, 0, 5, 1, 0, 0, 1, 0, 1, 0));
        // ADD R2 <- R1 + R2 (accepted at the earliest cycle after the previous one)
        run_instr("add", 12'h48A, 1'b0, 12'h000,
                  mk(0, 1, 2, 2, 0, 1, 0, 0, 0, 1, 0),
                  mk(1, 1, 2, 2, 1, 1, 0, 0, 0, 1, 0));
        // SUB R3 <- R1 - R3
        run_instr("sub", 12'h6CB, 1'b0, 12'h000,
                  mk(0, 1, 3, 3, 0, 1, 1, 0, 0, 1, 0),
                  mk(1, 1, 3, 3, 1, 1, 1, 0, 0, 1, 0));
        // External STORE DM[3] <- R7; ROM holds an ADD that must be ignored
        run_instr("ext_store", 12'h48A, 1'b1, 12'h237,
                  mk(0, 0, 7, 0, 0, 0, 0, 3, 1, 1, 0),
                  mk(0, 0, 7, 0, 0, 0, 0, 3, 0, 1, 0));
        // NOP opcode 100
        run_instr("nop", 12'h8FF, 1'b0, 12'h000,
                  mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0),
                  mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));

        // Step pulses at cycles 0, 2, 4: only the first is accepted
        im_data = 12'h015;
        pcs = 0; bsy = 0;
        for (int c = 0; c < 12; c++) begin
            step = (c == 0) || (c == 2) || (c == 4);
            cyc();
            pcs += int'(pc_inc);
            bsy += int'(busy);
        end
        step = 1'b0;
        chk("multi_step_pc_inc_count", 32'(pcs), 32'd1);
        chk("multi_step_busy_cycles", 32'(bsy), 32'd4);

        // Reset asserted in EXEC of a STORE
        im_data = 12'h237;
        step = 1'b1;
        cyc();
        step = 1'b0;
        cyc();
        @(posedge clk);
        #1 rst = 1'b1;
        #1 chk("rst_in_exec_outputs", 32'(snap()), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        bad = 0;
        for (int c = 0; c < 6; c++) begin
            cyc();
            bad += int'(dm_we) + int'(pc_inc) + int'(rf_we) + int'(busy);
        end
        chk("rst_no_pending_ctl", 32'(bad), 32'd0);

        // HALT, then steps and run ticks are ignored until reset
        im_data = 12'hE00;
        step = 1'b1;
        cyc();
        step = 1'b0;
        cyc();
        cyc();
        chk("halt_exec", 32'(snap()), 32'(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0)));
        cyc();
        chk("halt_entered", 32'(snap()), 32'(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1)));
        im_data = 12'h48A;
        run = 1'b1;
        pcs = 0; bsy = 0; hlt = 0;
        for (int c = 0; c < 20; c++) begin
            step = c[0];
            cyc();
            pcs += int'(pc_inc);
            bsy += int'(busy);
            hlt += int'(halted);
        end
        step = 1'b0;
        run  = 1'b0;
        chk("halted_pc_inc_count", 32'(pcs), 32'd0);
        chk("halted_busy_count", 32'(bsy), 32'd0);
        chk("halted_held", 32'(hlt), 32'd20);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        cyc();
        chk("halt_cleared_by_rst", 32'(snap()), 32'd0);

        // Run mode, period 8: pc_inc at cycles 11, 19, 27, 35 after run rises.
        // A manual step coincides with the tick at edge 16 and must not add one.
        im_data = 12'h48A;
        run = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            step = (c == 16);
            cyc();
            exp_pc = (c == 11) || (c == 19) || (c == 27) || (c == 35);
            chk($sformatf("run_pc_inc_c%0d", c), 32'(pc_inc), 32'(exp_pc));
        end
        step = 1'b0;
        run  = 1'b0;
        // The instruction accepted on the tick at edge 40 still completes
        pcs = 0;
        for (int c = 0; c < 20; c++) begin
            cyc();
            pcs += int'(pc_inc);
        end
        chk("run_stop_pc_inc_count", 32'(pcs), 32'd1);
        chk("run_stop_idle", 32'(snap()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
